// File: rtl/branch_pht_pkg.sv
// Shared types and helpers for the bimodal PHT scheduler: FSM states,
// 2-bit counter encodings, saturating update and the update-queue entry.
package branch_pht_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  // Widest index a 32-bit word-aligned PC can produce; tops narrow it as needed.
  localparam int unsigned PC_IDX_W = 30;

  typedef struct packed {
    logic [PC_IDX_W-1:0] index;
    logic                taken;
  } upd_entry_t;

  function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
    logic [1:0] res;
    res = cnt;
    if (taken) begin
      if (cnt != STRONG_T) res = cnt + 2'd1;
    end else begin
      if (cnt != STRONG_NT) res = cnt - 2'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_pht_upd_queue.sv
// FIFO of resolved-branch updates awaiting a PHT read-modify-write slot.
// Full/empty decode the registered count, so a pop frees a slot only next cycle.
module branch_pht_upd_queue
  import branch_pht_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  upd_entry_t push_data,
  input  logic       pop,
  output upd_entry_t head,
  output logic       full,
  output logic       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  upd_entry_t        mem_q [DEPTH];
  upd_entry_t        mem_d [DEPTH];
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by the count.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/branch_pht_sched.sv
// Arbitrates the PHT read/write ports between fetch lookups and queued updates.
// Define BRANCH_PHT_SCHED_SWEEP_EN to sweep the table to weakly-not-taken after reset/flush.
module branch_pht_sched
  import branch_pht_pkg::*;
#(
  parameter int unsigned PHT_size     = 2048,
  parameter int unsigned QUEUE_DEPTH  = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        flush,
  input  logic                        lookup_val,
  input  logic [31:0]                 lookup_pc,
  output logic                        lookup_rdy,
  output logic                        prediction,
  input  logic                        upd_val,
  input  logic [31:0]                 upd_pc,
  input  logic                        upd_taken,
  output logic                        upd_rdy,
  output logic [$clog2(PHT_size)-1:0] pht_raddr,
  input  logic [1:0]                  pht_rdata,
  output logic                        pht_wen,
  output logic [$clog2(PHT_size)-1:0] pht_waddr,
  output logic [1:0]                  pht_wdata,
  output logic                        busy
);

  localparam int unsigned IDX_W = $clog2(PHT_size);
  localparam int unsigned STV_W = $clog2(STARVE_LIMIT + 1);
`ifdef BRANCH_PHT_SCHED_SWEEP_EN
  localparam state_e ST_RESET = ST_INIT;
`else
  localparam state_e ST_RESET = ST_RUN;
`endif

  state_e            state_q, state_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              kill, q_full, q_empty, q_push, drain, lookup_win;
  logic [IDX_W-1:0]  lookup_idx, head_idx;
  upd_entry_t        push_entry, head_entry;
  logic              unused_bits;

  assign kill       = reset | flush;
  assign lookup_idx = lookup_pc[IDX_W+1:2];
  assign head_idx   = IDX_W'(head_entry.index);
  assign push_entry = '{index: PC_IDX_W'(upd_pc[IDX_W+1:2]), taken: upd_taken};
  assign upd_rdy    = ~q_full;
  assign q_push     = upd_val & upd_rdy & ~kill;
  assign prediction = pht_rdata[1];
  assign unused_bits = ^{lookup_pc, upd_pc, head_entry};

  // Drain wins when fetch is idle, the queue is full, or updates have starved.
  assign drain = (state_q == ST_RUN) & ~kill & ~q_empty &
                 (~lookup_val | q_full | (starve_q == STV_W'(STARVE_LIMIT)));
  assign lookup_win = (state_q == ST_RUN) & ~drain;

  branch_pht_upd_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (q_push),
    .push_data (push_entry),
    .pop       (drain),
    .head      (head_entry),
    .full      (q_full),
    .empty     (q_empty)
  );

`ifdef BRANCH_PHT_SCHED_SWEEP_EN
  logic [IDX_W-1:0] sweep_idx_q, sweep_idx_d;

  always_comb begin
    sweep_idx_d = sweep_idx_q;
    if (flush) sweep_idx_d = '0;
    else if (state_q == ST_INIT) sweep_idx_d = sweep_idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) sweep_idx_q <= '0;
    else       sweep_idx_q <= sweep_idx_d;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_RESET;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
`ifdef BRANCH_PHT_SCHED_SWEEP_EN
    if (flush) state_d = ST_INIT;
    else if (state_q == ST_INIT && sweep_idx_q == IDX_W'(PHT_size - 1)) state_d = ST_RUN;
`else
    state_d = ST_RUN;
`endif
  end

  // Counts lookup wins while updates wait; any drain or an empty queue resets it.
  always_comb begin
    starve_d = starve_q;
    if (q_empty || drain) starve_d = '0;
    else if (lookup_win && !kill && starve_q != STV_W'(STARVE_LIMIT))
      starve_d = starve_q + STV_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  always_comb begin
    pht_raddr  = lookup_idx;
    lookup_rdy = 1'b0;
    pht_wen    = 1'b0;
    pht_waddr  = head_idx;
    pht_wdata  = sat_update(pht_rdata, head_entry.taken);
    busy       = ~q_empty;
    case (state_q)
`ifdef BRANCH_PHT_SCHED_SWEEP_EN
      ST_INIT: begin
        pht_wen   = 1'b1;
        pht_waddr = sweep_idx_q;
        pht_wdata = WEAK_NT;
        busy      = 1'b1;
      end
`endif
      ST_RUN: begin
        if (drain) begin
          pht_raddr = head_idx;
          pht_wen   = 1'b1;
        end else begin
          lookup_rdy = lookup_val;
        end
      end
      default: ;
    endcase
  end

endmodule
